// File: rtl/occ_mem_responder_if.sv
// Occ-table read/load bundle: ce/addr request, data/valid response,
// ld_we/ld_addr/ld_data table load port, busy status.
interface occ_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ce;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;

  modport master (
    output ce, addr, ld_we, ld_addr, ld_data,
    input  data, valid, busy
  );

  modport slave (
    input  ce, addr, ld_we, ld_addr, ld_data,
    output data, valid, busy
  );
endinterface

// File: rtl/occ_mem_responder.sv
// Occ-table responder: loadable 2**ADDR_W x DATA_W array, LATENCY-cycle
// miss path, one-entry last-address hit path. Ports: clk, rst, bus(slave).
module occ_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  occ_mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_tag_addr;
  logic              r_tag_v;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_rd;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_ld_tag;
  logic              w_ld_req;
  logic              w_hit;

  // A load to the tagged word in the accept cycle must force a miss.
  assign w_ld_tag = bus.ld_we && (bus.ld_addr == r_tag_addr);
  assign w_ld_req = bus.ld_we && (bus.ld_addr == r_req_addr);
  assign w_hit    = r_tag_v && (bus.addr == r_tag_addr) && !w_ld_tag;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rd        = 1'b0;
    w_rd_addr   = r_req_addr;
    unique case (r_state)
      S_IDLE: begin
        if (bus.ce) begin
          w_accept = 1'b1;
          if (w_hit || (LATENCY == 1)) begin
            w_state_nxt = S_RESP;
            w_rd        = 1'b1;
            w_rd_addr   = bus.addr;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (!bus.ce) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
          w_rd        = 1'b1;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_req_addr <= '0;
      r_tag_addr <= '0;
      r_tag_v    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_accept) r_req_addr <= bus.addr;
      // Same-edge loads are not visible: old word is captured.
      if (w_rd) r_data <= r_mem[w_rd_addr];
      if (r_state == S_RESP) begin
        r_tag_addr <= r_req_addr;
        r_tag_v    <= !w_ld_req;
      end else if (w_ld_tag) begin
        r_tag_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.ld_we) r_mem[bus.ld_addr] <= bus.ld_data;
  end

  assign bus.valid = (r_state == S_RESP);
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.data  = r_data;

endmodule
